osnt_wrr_scheduler: RTL and testbench
=====================================

// Module: osnt_wrr_scheduler
// PURPOSE
//  Packet-granular weighted round-robin scheduler for the OSNT input arbiter.
//  It decides which slave stream may own the shared master AXI-Stream output.
//  It watches per-port "head of packet pending" requests and the end of each packet
//  on the master side, then issues a one-hot grant.
//  Each port gets up to WEIGHT[i] consecutive packets per round.
// PARAMETERS
//  NUM_PORTS     4  number of requesting slave streams (2..8)
//  IDX_WIDTH     2  width of grant_idx, = clog2(NUM_PORTS)
//  WEIGHT_WIDTH  4  bits per weight/credit; weight 0 disables the port
//  CNT_WIDTH    32  width of round_cnt
// PORTS
//  axi_aclk       in   1                       clock; all logic is on its rising edge
//  axi_reset      in   1                       synchronous, active-high reset
//  req            in   NUM_PORTS               req[i]=1: port i has a packet head pending (its tvalid)
//  weight         in   NUM_PORTS*WEIGHT_WIDTH  weight of port i = weight[i*WW +: WW]
//  pkt_done       in   1                       master tvalid&tready&tlast (last beat of a packet accepted)
//  grant          out  NUM_PORTS               one-hot owner of the output; all-zero when idle
//  grant_valid    out  1                       1 while a grant is held
//  grant_idx      out  IDX_WIDTH               binary index of the granted port (0 when idle)
//  round_cnt      out  CNT_WIDTH               count of credit reloads; wraps modulo 2^CNT_WIDTH
//  spurious_done  out  1                       sticky flag: pkt_done seen while in IDLE
// BEHAVIOUR
//  Reset values
//   - Outputs: grant, grant_valid, grant_idx, round_cnt and spurious_done all 0.
//   - Internal: credit[] = 0, ptr = 0, state = IDLE.
//   - Reset asserted mid-packet takes effect at the next edge; the grant is dropped.
//  Definitions
//   - eligible[i] = req[i] & (credit[i] != 0).
//   - sel = first eligible port scanning cyclically from ptr (ptr itself included).
//  FSM, two states
//   - IDLE, some port eligible
//       - Next edge: grant = onehot(sel), grant_idx = sel, grant_valid = 1.
//       - credit[sel] decrements by 1; state -> GRANT.
//       - Latency: req to grant_valid is 1 cycle.
//   - IDLE, none eligible, but some port has req[i] & (weight[i] != 0)
//       - Round boundary. Next edge: credit[i] = weight[i] for every i; round_cnt increments.
//       - State stays IDLE; selection happens the following cycle (req to grant is 2 cycles).
//   - IDLE, otherwise: hold.
//       - pkt_done=1 in IDLE sets spurious_done (sticky until reset); nothing else changes.
//   - GRANT
//       - grant is held unchanged until pkt_done=1. Deasserting req does not release it;
//         packets are never aborted.
//       - On the pkt_done edge: grant = 0, grant_valid = 0, grant_idx = 0, state -> IDLE.
//       - At the same edge: ptr = (credit[sel] == 0) ? (sel+1) mod NUM_PORTS : sel.
//         The port keeps priority while it has credit, giving burst WRR.
//  Bubble
//   - There is always exactly one IDLE cycle between successive grants.
//   - The next grant is therefore visible 2 cycles after pkt_done (3 cycles if a reload is needed).
//  Weights
//   - weight is sampled only at a reload. Changing it mid-round does not alter current credits.
//   - A port with weight 0 is never granted, even while it requests.
//  Arithmetic
//   - credit never underflows: it is decremented only when nonzero.
//   - ptr wraps from NUM_PORTS-1 to 0.
//   - round_cnt wraps to 0 after its all-ones value.
// TESTING
//  1. axi_reset=1 for 50 cycles, req=4'hF -> grant=0, grant_valid=0, round_cnt=0, spurious_done=0 throughout.
//  2. req=4'b0100, weight[2]=3, others 0; pkt_done 8 cycles after each grant ->
//     round_cnt=1 at cycle 1, grant=4'b0100 at cycle 2; 3 packets, then round_cnt=2 before the 4th grant.
//  3. req=4'hF, weights {1,2,3,4} (port 0..3), m side always done after 4 beats ->
//     per-round grant order 0,1,1,2,2,2,3,3,3,3; counts over 40 packets are 4:8:12:16.
//  4. req=4'hF, weight[1]=0, others 2 -> port 1 is never granted; order 0,0,2,2,3,3 repeats.
//  5. pkt_done pulse with grant_valid=0 -> spurious_done=1 next edge and stays; grant stays 0.
//  6. Mid-packet (grant=4'b0001), drop req[0] -> grant is held until pkt_done.
//     Then raise axi_reset during the next grant -> all outputs are 0 at the following edge.

Source files
------------

// File: rtl/osnt_wrr_scheduler.sv
// Packet-granular weighted round-robin arbiter: one-hot grant held for a whole
// packet; each port gets up to its weight in consecutive packets per round.
module osnt_wrr_scheduler #(
  parameter int NUM_PORTS    = 4,
  parameter int IDX_WIDTH    = 2,
  parameter int WEIGHT_WIDTH = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                              axi_aclk,
  input  logic                              axi_reset,
  input  logic [NUM_PORTS-1:0]              req,
  input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weight,
  input  logic                              pkt_done,
  output logic [NUM_PORTS-1:0]              grant,
  output logic                              grant_valid,
  output logic [IDX_WIDTH-1:0]              grant_idx,
  output logic [CNT_WIDTH-1:0]              round_cnt,
  output logic                              spurious_done
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                                  state;
  logic [NUM_PORTS-1:0][WEIGHT_WIDTH-1:0]  credit;
  logic [NUM_PORTS-1:0][WEIGHT_WIDTH-1:0]  wt;
  logic [NUM_PORTS-1:0]                    eligible;
  logic [NUM_PORTS-1:0]                    reloadable;
  logic [IDX_WIDTH-1:0]                    ptr;
  logic [IDX_WIDTH-1:0]                    sel;
  logic [IDX_WIDTH-1:0]                    ptr_next;
  logic                                    any_elig;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign wt[i]         = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign eligible[i]   = req[i] & (credit[i] != '0);
    assign reloadable[i] = req[i] & (wt[i] != '0);
  end

  // Scan from the farthest offset down so the port closest to ptr wins.
  always_comb begin
    sel      = ptr;
    any_elig = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      int                   p;
      logic [IDX_WIDTH-1:0] pi;
      p = int'(ptr) + k;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      pi = IDX_WIDTH'(p);
      if (eligible[pi]) begin
        sel      = pi;
        any_elig = 1'b1;
      end
    end
  end

  // A port keeps priority while it still holds credit (burst WRR).
  always_comb begin
    ptr_next = grant_idx;
    if (credit[grant_idx] == '0)
      ptr_next = (grant_idx == IDX_WIDTH'(NUM_PORTS - 1)) ? '0 : grant_idx + IDX_WIDTH'(1);
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state         <= IDLE;
      credit        <= '0;
      ptr           <= '0;
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_idx     <= '0;
      round_cnt     <= '0;
      spurious_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pkt_done) spurious_done <= 1'b1;
          if (any_elig) begin
            grant       <= NUM_PORTS'(1) << sel;
            grant_valid <= 1'b1;
            grant_idx   <= sel;
            credit[sel] <= credit[sel] - WEIGHT_WIDTH'(1);
            state       <= GRANT;
          end else if (|reloadable) begin
            credit    <= wt;
            round_cnt <= round_cnt + CNT_WIDTH'(1);
          end
        end
        GRANT: begin
          if (pkt_done) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            ptr         <= ptr_next;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osnt_wrr_scheduler.sv
// Bench for osnt_wrr_scheduler: cycle model of the arbitration rules plus
// directed scenarios with hand-derived grant orders and counts.
module tb_osnt_wrr_scheduler;
  localparam int N  = 4;
  localparam int WW = 4;

  logic          axi_aclk = 1'b0;
  logic          axi_reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*WW-1:0] weight = '0;
  logic          auto_done = 1'b0;
  logic          man_done = 1'b0;
  logic          pkt_done;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [1:0]    grant_idx;
  logic [31:0]   round_cnt;
  logic          spurious_done;

  assign pkt_done = auto_done | man_done;

  osnt_wrr_scheduler #(.NUM_PORTS(N), .IDX_WIDTH(2), .WEIGHT_WIDTH(WW), .CNT_WIDTH(32)) dut (
    .axi_aclk(axi_aclk), .axi_reset(axi_reset), .req(req), .weight(weight),
    .pkt_done(pkt_done), .grant(grant), .grant_valid(grant_valid),
    .grant_idx(grant_idx), .round_cnt(round_cnt), .spurious_done(spurious_done));

  always #5 axi_aclk = ~axi_aclk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Behavioural model: which port owns the output and how much credit remains.
  int        m_credit[N];
  int        m_ptr = 0;
  int        m_owner = 0;
  bit        m_busy = 0;
  bit        m_spur = 0;
  bit [31:0] m_round = 0;

  initial forever begin
    int  pick;
    bit  any_w;
    @(posedge axi_aclk);
    if (axi_reset) begin
      foreach (m_credit[i]) m_credit[i] = 0;
      m_ptr = 0; m_owner = 0; m_busy = 0; m_spur = 0; m_round = 0;
    end else if (m_busy) begin
      if (pkt_done) begin
        m_busy = 0;
        m_ptr  = (m_credit[m_owner] == 0) ? (m_owner + 1) % N : m_owner;
      end
    end else begin
      if (pkt_done) m_spur = 1;
      pick  = -1;
      any_w = 0;
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (pick < 0 && req[p] && m_credit[p] > 0) pick = p;
        if (req[k] && ((weight >> (WW*k)) & 4'hF) != 0) any_w = 1;
      end
      if (pick >= 0) begin
        m_busy  = 1;
        m_owner = pick;
        m_credit[pick] = m_credit[pick] - 1;
      end else if (any_w) begin
        for (int k = 0; k < N; k++) m_credit[k] = int'((weight >> (WW*k)) & 4'hF);
        m_round = m_round + 1;
      end
    end
  end

  initial begin
    @(posedge axi_aclk);
    forever begin
      @(negedge axi_aclk);
      chk("cyc_grant", grant, m_busy ? (1 << m_owner) : 0);
      chk("cyc_valid", grant_valid, m_busy);
      chk("cyc_idx", grant_idx, m_busy ? m_owner : 0);
      chk("cyc_round", round_cnt, m_round);
      chk("cyc_spur", spurious_done, m_spur);
    end
  end

  // Log of granted ports, one entry per new grant.
  int glog[$];
  bit prev_v = 0;
  initial forever begin
    @(negedge axi_aclk);
    if (grant_valid && !prev_v) glog.push_back(int'(grant_idx));
    prev_v = grant_valid;
  end

  // Master side: finish each packet after auto_beats accepted beats.
  int auto_beats = 0;
  int beat = 0;
  initial forever begin
    @(negedge axi_aclk);
    if (auto_beats > 0 && grant_valid) begin
      beat++;
      if (beat >= auto_beats) begin auto_done = 1'b1; beat = 0; end
      else auto_done = 1'b0;
    end else begin
      auto_done = 1'b0;
      beat = 0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge axi_aclk); #1; end
  endtask

  task automatic do_reset();
    axi_reset = 1'b1;
    tick(3);
    axi_reset = 1'b0;
    glog.delete();
  endtask

  task automatic wait_grants(input string nm, input int n, input int budget);
    int c = 0;
    while (glog.size() < n && c < budget) begin tick(); c++; end
    chk(nm, glog.size() >= n, 1);
  endtask

  task automatic wait_valid(input string nm, input int budget, output int cycles);
    cycles = 0;
    while (!grant_valid && cycles < budget) begin tick(); cycles++; end
    chk(nm, grant_valid, 1);
  endtask

  int exp3[10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
  int exp4[6]  = '{0, 0, 2, 2, 3, 3};

  initial begin
    int cnt[N];
    int cyc;

    // 1: long reset with everything requesting
    req = 4'hF; weight = 16'h1111;
    repeat (50) begin
      tick();
      chk("t1_grant", grant, 0);
      chk("t1_valid", grant_valid, 0);
      chk("t1_round", round_cnt, 0);
      chk("t1_spur", spurious_done, 0);
    end

    // 2: single requester with weight 3
    req = 4'b0100; weight = 16'h0300; auto_beats = 8;
    axi_reset = 1'b0;
    glog.delete();
    tick();
    chk("t2_round_c1", round_cnt, 1);
    chk("t2_grant_c1", grant, 0);
    tick();
    chk("t2_grant_c2", grant, 4'b0100);
    chk("t2_valid_c2", grant_valid, 1);
    wait_grants("t2_wait4", 4, 200);
    chk("t2_round_at4", round_cnt, 2);
    foreach (glog[i]) chk("t2_port", glog[i], 2);
    req = 4'b0000;
    tick(12);

    // 3: weights 1,2,3,4 with all ports requesting
    req = 4'hF; weight = 16'h4321; auto_beats = 4;
    do_reset();
    wait_grants("t3_wait40", 40, 2000);
    foreach (cnt[i]) cnt[i] = 0;
    for (int i = 0; i < 40 && i < glog.size(); i++) begin
      chk("t3_order", glog[i], exp3[i % 10]);
      cnt[glog[i]]++;
    end
    chk("t3_cnt0", cnt[0], 4);
    chk("t3_cnt1", cnt[1], 8);
    chk("t3_cnt2", cnt[2], 12);
    chk("t3_cnt3", cnt[3], 16);
    chk("t3_round", round_cnt, 4);

    // 4: port 1 disabled by weight 0
    weight = 16'h2202;
    do_reset();
    wait_grants("t4_wait12", 12, 1000);
    for (int i = 0; i < 12 && i < glog.size(); i++) begin
      chk("t4_order", glog[i], exp4[i % 6]);
      chk("t4_no_port1", glog[i] == 1, 0);
    end

    // 5: pkt_done while idle
    auto_beats = 0; req = 4'b0000; weight = 16'h0000;
    tick(6);
    do_reset();
    chk("t5_spur_pre", spurious_done, 0);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("t5_spur", spurious_done, 1);
    chk("t5_grant", grant, 0);
    tick(5);
    chk("t5_spur_sticky", spurious_done, 1);

    // 6: grant held after req drops; reset mid-packet
    weight = 16'h0002; req = 4'b0001;
    do_reset();
    wait_valid("t6_first", 10, cyc);
    chk("t6_grant", grant, 4'b0001);
    req = 4'b0000;
    tick(5);
    chk("t6_hold_grant", grant, 4'b0001);
    chk("t6_hold_valid", grant_valid, 1);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("t6_release", grant, 0);
    req = 4'b0001;
    wait_valid("t6_second", 10, cyc);
    chk("t6_latency", cyc, 1);
    chk("t6_grant2", grant, 4'b0001);
    axi_reset = 1'b1;
    tick();
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_valid", grant_valid, 0);
    chk("t6_rst_idx", grant_idx, 0);
    chk("t6_rst_round", round_cnt, 0);
    chk("t6_rst_spur", spurious_done, 0);
    axi_reset = 1'b0;
    req = 4'b0000;
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
